shooter_controller: RTL

- Per-frame motion and fire controller for the player shooter drawn by the VGA colour mapper.
- Samples the keyboard keycode once per video frame and updates shooter position and facing, clamped to the map floor.
- Owns one projectile: spawn, per-frame flight, and retire at the floor edge.
- Outputs drive the colour mapper's ShooterX/ShooterY/ShooterFace inputs and the bullet sprite inputs directly.

---
 rtl/shooter_controller.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/shooter_controller.sv
// Per-frame shooter motion and single-projectile controller for the VGA colour mapper.
// Samples the keycode once per synchronised frame_clk rising edge and walks WAIT -> SHOOTER -> BULLET.
module shooter_controller #(
  parameter logic [9:0] START_X = 10'd304,
  parameter logic [9:0] START_Y = 10'd239,
  parameter logic [9:0] STEP    = 10'd2,
  parameter logic [9:0] BSTEP   = 10'd8,
  parameter logic [9:0] MIN_X   = 10'd32,
  parameter logic [9:0] MAX_X   = 10'd607,
  parameter logic [9:0] MIN_Y   = 10'd62,
  parameter logic [9:0] MAX_Y   = 10'd447,
  parameter logic [9:0] SPR     = 10'd32,
  parameter logic [9:0] BSZ     = 10'd4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic [9:0] ShooterX,
  output logic [9:0] ShooterY,
  output logic [1:0] ShooterFace,
  output logic [9:0] BulletX,
  output logic [9:0] BulletY,
  output logic       BulletActive
);

  localparam logic [7:0] KEY_UP    = 8'h1A;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_DOWN  = 8'h16;
  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_FIRE  = 8'h2C;

  localparam logic signed [10:0] STEP_S   = $signed({1'b0, STEP});
  localparam logic signed [10:0] BSTEP_S  = $signed({1'b0, BSTEP});
  localparam logic signed [10:0] MIN_X_S  = $signed({1'b0, MIN_X});
  localparam logic signed [10:0] MIN_Y_S  = $signed({1'b0, MIN_Y});
  localparam logic signed [10:0] MAX_X_S  = $signed({1'b0, MAX_X});
  localparam logic signed [10:0] MAX_Y_S  = $signed({1'b0, MAX_Y});
  localparam logic signed [10:0] BSZ_M1_S = $signed({1'b0, BSZ}) - 11'sd1;
  // Last legal upper-left corner keeping the whole sprite on the floor.
  localparam logic signed [10:0] SX_MAX_S = MAX_X_S + 11'sd1 - $signed({1'b0, SPR});
  localparam logic signed [10:0] SY_MAX_S = MAX_Y_S + 11'sd1 - $signed({1'b0, SPR});
  localparam logic [9:0]         HALF     = (SPR - BSZ) >> 1;

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_SHOOTER = 2'd1,
    ST_BULLET  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] sync_q;
  logic       tick_s;
  logic [7:0] key_q, key_d;
  logic [9:0] sx_q, sx_d, sy_q, sy_d;
  logic [1:0] face_q, face_d;
  logic [9:0] bx_q, bx_d, by_q, by_d;
  logic       bact_q, bact_d;
  logic [1:0] bdir_q, bdir_d;
  logic       fire_prev_q, fire_prev_d;

  logic signed [10:0] sx_s, sy_s, bx_s, by_s;
  logic signed [10:0] up_s, down_s, left_s, right_s;
  logic signed [10:0] bnx_s, bny_s;
  logic               bout_s;
  logic               spawn_s;

  // sync_q[1] is the synchronised level, sync_q[2] its one-cycle-delayed copy.
  assign tick_s = sync_q[1] & ~sync_q[2];

  assign sx_s    = $signed({1'b0, sx_q});
  assign sy_s    = $signed({1'b0, sy_q});
  assign bx_s    = $signed({1'b0, bx_q});
  assign by_s    = $signed({1'b0, by_q});
  assign up_s    = sy_s - STEP_S;
  assign down_s  = sy_s + STEP_S;
  assign left_s  = sx_s - STEP_S;
  assign right_s = sx_s + STEP_S;

  assign spawn_s = (key_q == KEY_FIRE) && !fire_prev_q && !bact_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], frame_clk};
    end
  end

  // Candidate bullet position one flight step along bdir, and whether it leaves the floor.
  always_comb begin
    bnx_s = bx_s;
    bny_s = by_s;
    case (bdir_q)
      2'd0:    bny_s = by_s - BSTEP_S;
      2'd1:    bnx_s = bx_s + BSTEP_S;
      2'd2:    bny_s = by_s + BSTEP_S;
      2'd3:    bnx_s = bx_s - BSTEP_S;
      default: bnx_s = bx_s;
    endcase
    bout_s = (bnx_s < MIN_X_S) || (bny_s < MIN_Y_S) ||
             ((bnx_s + BSZ_M1_S) > MAX_X_S) || ((bny_s + BSZ_M1_S) > MAX_Y_S);
  end

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    face_d      = face_q;
    bx_d        = bx_q;
    by_d        = by_q;
    bact_d      = bact_q;
    bdir_d      = bdir_q;
    fire_prev_d = fire_prev_q;
    case (state_q)
      ST_WAIT: begin
        if (tick_s) begin
          key_d   = keycode;
          state_d = ST_SHOOTER;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_SHOOTER: begin
        case (key_q)
          KEY_UP: begin
            face_d = 2'd0;
            if (up_s < MIN_Y_S) sy_d = MIN_Y;
            else                sy_d = up_s[9:0];
          end
          KEY_RIGHT: begin
            face_d = 2'd1;
            if (right_s > SX_MAX_S) sx_d = SX_MAX_S[9:0];
            else                    sx_d = right_s[9:0];
          end
          KEY_DOWN: begin
            face_d = 2'd2;
            if (down_s > SY_MAX_S) sy_d = SY_MAX_S[9:0];
            else                   sy_d = down_s[9:0];
          end
          KEY_LEFT: begin
            face_d = 2'd3;
            if (left_s < MIN_X_S) sx_d = MIN_X;
            else                  sx_d = left_s[9:0];
          end
          default: face_d = face_q;
        endcase
        state_d = ST_BULLET;
      end
      ST_BULLET: begin
        if (spawn_s) begin
          bx_d   = sx_q + HALF;
          by_d   = sy_q + HALF;
          bdir_d = face_q;
          bact_d = 1'b1;
        end else if (bact_q) begin
          // No partial step: a bullet that would cross the wall retires in place.
          if (bout_s) begin
            bact_d = 1'b0;
          end else begin
            bx_d = bnx_s[9:0];
            by_d = bny_s[9:0];
          end
        end else begin
          bact_d = 1'b0;
        end
        fire_prev_d = (key_q == KEY_FIRE);
        state_d     = ST_WAIT;
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_WAIT;
      key_q       <= 8'h00;
      sx_q        <= START_X;
      sy_q        <= START_Y;
      face_q      <= 2'd0;
      bx_q        <= 10'd0;
      by_q        <= 10'd0;
      bact_q      <= 1'b0;
      bdir_q      <= 2'd0;
      fire_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      face_q      <= face_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      bact_q      <= bact_d;
      bdir_q      <= bdir_d;
      fire_prev_q <= fire_prev_d;
    end
  end

  assign ShooterX     = sx_q;
  assign ShooterY     = sy_q;
  assign ShooterFace  = face_q;
  assign BulletX      = bx_q;
  assign BulletY      = by_q;
  assign BulletActive = bact_q;

endmodule
